// File: rtl/mux_arb_nto1.sv
// N-to-1 bus multiplexer with fixed-select or round-robin arbitration, feeding a
// single-entry output register with a valid/ready handshake.
module mux_arb_nto1 #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned SEL_W    = 2
) (
  input  logic                      input_clock,
  input  logic                      input_reset,
  input  logic [CHANNELS*WIDTH-1:0] input_data,
  input  logic [CHANNELS-1:0]       input_valid,
  output logic [CHANNELS-1:0]       output_accept,
  input  logic                      input_mode,
  input  logic [SEL_W-1:0]          input_select,
  output logic [WIDTH-1:0]          output_result,
  output logic [SEL_W-1:0]          output_channel,
  output logic                      output_valid,
  input  logic                      input_ready
);

  logic [WIDTH-1:0] result_q;
  logic [SEL_W-1:0] channel_q;
  logic             valid_q;
  logic [SEL_W-1:0] last_grant_q;

  logic             load_slot;
  logic             grant;
  logic [SEL_W-1:0] grant_idx;
  logic [WIDTH-1:0] grant_word;

  assign load_slot = !valid_q || input_ready;

  always_comb begin
    grant     = 1'b0;
    grant_idx = '0;
    if (!input_reset && load_slot) begin
      if (!input_mode) begin
        // An out-of-range select matches no channel and so never grants.
        for (int k = 0; k < int'(CHANNELS); k++) begin
          if (input_select == SEL_W'(k) && input_valid[k]) begin
            grant     = 1'b1;
            grant_idx = SEL_W'(k);
          end
        end
      end else begin
        // Scan from the farthest offset down so the nearest valid channel wins.
        for (int i = int'(CHANNELS); i >= 1; i--) begin
          for (int k = 0; k < int'(CHANNELS); k++) begin
            if (k == (int'(last_grant_q) + i) % int'(CHANNELS) && input_valid[k]) begin
              grant     = 1'b1;
              grant_idx = SEL_W'(k);
            end
          end
        end
      end
    end
  end

  always_comb begin
    grant_word = '0;
    for (int k = 0; k < int'(CHANNELS); k++) begin
      if (grant_idx == SEL_W'(k)) begin
        grant_word = input_data[k*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    output_accept = '0;
    for (int k = 0; k < int'(CHANNELS); k++) begin
      output_accept[k] = grant && (grant_idx == SEL_W'(k));
    end
  end

  always_ff @(posedge input_clock) begin
    if (input_reset) begin
      result_q     <= '0;
      channel_q    <= '0;
      valid_q      <= 1'b0;
      last_grant_q <= SEL_W'(CHANNELS - 1);
    end else if (load_slot) begin
      if (grant) begin
        result_q     <= grant_word;
        channel_q    <= grant_idx;
        valid_q      <= 1'b1;
        last_grant_q <= grant_idx;
      end else begin
        valid_q <= 1'b0;
      end
    end
  end

  assign output_result  = result_q;
  assign output_channel = channel_q;
  assign output_valid   = valid_q;

endmodule

// File: tb/tb_mux_arb_nto1.sv
// Randomised and directed bench for mux_arb_nto1 against a behavioural model of
// the select/arbitration rules and the single-entry output register.
module tb_mux_arb_nto1;
  localparam int W  = 8;
  localparam int CH = 4;
  localparam int SW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [CH*W-1:0] data;
  logic [CH-1:0]   vld;
  logic [CH-1:0]   acc;
  logic            mode;
  logic [SW-1:0]   sel;
  logic [W-1:0]    res;
  logic [SW-1:0]   chn;
  logic            ov;
  logic            rdy;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state
  int m_res   = 0;
  int m_chn   = 0;
  int m_last  = CH - 1;
  bit m_valid = 1'b0;

  always #5 clk = ~clk;

  mux_arb_nto1 #(.WIDTH(W), .CHANNELS(CH), .SEL_W(SW)) dut (
    .input_clock   (clk),
    .input_reset   (rst),
    .input_data    (data),
    .input_valid   (vld),
    .output_accept (acc),
    .input_mode    (mode),
    .input_select  (sel),
    .output_result (res),
    .output_channel(chn),
    .output_valid  (ov),
    .input_ready   (rdy)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Grant by rule: fixed picks the selected valid channel; round-robin picks the
  // valid channel at the smallest circular distance past the last grant.
  task automatic model_grant(output bit g, output int gi);
    int best_d;
    g      = 1'b0;
    gi     = 0;
    best_d = CH;
    if (rst || (m_valid && !rdy)) return;
    if (!mode) begin
      if (int'(sel) < CH && vld[sel]) begin
        g  = 1'b1;
        gi = int'(sel);
      end
    end else begin
      for (int c = 0; c < CH; c++) begin
        int d;
        d = (c - m_last - 1 + 2 * CH) % CH;
        if (vld[c] && d < best_d) begin
          best_d = d;
          g      = 1'b1;
          gi     = c;
        end
      end
    end
  endtask

  task automatic cycle(input bit r, input logic [CH-1:0] v, input bit md, input int s,
                       input bit rd, input logic [CH*W-1:0] d);
    bit g;
    int gi;
    @(negedge clk);
    rst  = r;
    vld  = v;
    mode = md;
    sel  = s[SW-1:0];
    rdy  = rd;
    data = d;
    #1;
    model_grant(g, gi);
    check_eq("accept", 32'(acc), g ? (32'd1 << gi) : 32'd0);
    @(posedge clk);
    if (r) begin
      m_res   = 0;
      m_chn   = 0;
      m_valid = 1'b0;
      m_last  = CH - 1;
    end else if (!m_valid || rd) begin
      if (g) begin
        m_res   = int'(d[gi*W +: W]);
        m_chn   = gi;
        m_valid = 1'b1;
        m_last  = gi;
      end else begin
        m_valid = 1'b0;
      end
    end
    #1;
    check_eq("valid", 32'(ov), 32'(m_valid));
    check_eq("result", 32'(res), 32'(m_res));
    check_eq("channel", 32'(chn), 32'(m_chn));
  endtask

  initial begin
    logic [CH*W-1:0] pat;
    logic [CH*W-1:0] rnd;
    int              rr_seq [6];
    int              rr_alt [4];

    rst  = 1'b1;
    vld  = '0;
    mode = 1'b0;
    sel  = '0;
    rdy  = 1'b1;
    data = '0;
    pat  = {8'h55, 8'hAA, 8'hFF, 8'h00};

    cycle(1, 4'b0000, 0, 0, 1, pat);
    cycle(1, 4'b0000, 0, 0, 1, pat);
    check_eq("rst_valid", 32'(ov), 32'd0);
    check_eq("rst_result", 32'(res), 32'd0);

    // Fixed select walk
    for (int s = 0; s < CH; s++) cycle(0, 4'b1111, 0, s, 1, pat);
    check_eq("fixed_last_result", 32'(res), 32'h55);
    check_eq("fixed_last_channel", 32'(chn), 32'd3);

    // Selected channel not valid
    cycle(0, 4'b1011, 0, 2, 1, pat);
    check_eq("fixed_novalid_ov", 32'(ov), 32'd0);
    check_eq("fixed_novalid_hold", 32'(res), 32'h55);

    // Round-robin, all valid
    cycle(1, 4'b0000, 1, 0, 1, pat);
    for (int i = 0; i < 6; i++) begin
      cycle(0, 4'b1111, 1, 0, 1, pat);
      rr_seq[i] = int'(chn);
    end
    check_eq("rr_seq0", 32'(rr_seq[0]), 32'd0);
    check_eq("rr_seq3", 32'(rr_seq[3]), 32'd3);
    check_eq("rr_seq4_wrap", 32'(rr_seq[4]), 32'd0);
    check_eq("rr_seq5", 32'(rr_seq[5]), 32'd1);

    // Round-robin, only ch1 and ch3 valid
    cycle(1, 4'b0000, 1, 0, 1, pat);
    for (int i = 0; i < 4; i++) begin
      cycle(0, 4'b1010, 1, 0, 1, pat);
      rr_alt[i] = int'(chn);
    end
    check_eq("rr_alt0", 32'(rr_alt[0]), 32'd1);
    check_eq("rr_alt1", 32'(rr_alt[1]), 32'd3);
    check_eq("rr_alt2", 32'(rr_alt[2]), 32'd1);
    check_eq("rr_alt3", 32'(rr_alt[3]), 32'd3);

    // Back-pressure hold then drain-and-load
    pat = {8'h00, 8'h5A, 8'h00, 8'h11};
    cycle(0, 4'b0100, 0, 2, 1, pat);
    for (int i = 0; i < 3; i++) cycle(0, 4'b0001, 1, 0, 0, pat);
    check_eq("bp_hold_result", 32'(res), 32'h5A);
    check_eq("bp_hold_valid", 32'(ov), 32'd1);
    cycle(0, 4'b0001, 1, 0, 1, pat);
    check_eq("bp_release_result", 32'(res), 32'h11);

    // Reset during hold
    cycle(0, 4'b0100, 0, 2, 1, pat);
    cycle(0, 4'b0001, 0, 0, 0, pat);
    cycle(1, 4'b0001, 0, 0, 0, pat);
    check_eq("rst_hold_valid", 32'(ov), 32'd0);
    check_eq("rst_hold_result", 32'(res), 32'd0);
    cycle(0, 4'b0110, 1, 0, 1, pat);
    check_eq("rst_hold_first_rr", 32'(chn), 32'd1);

    // Random traffic
    for (int i = 0; i < 2000; i++) begin
      rnd = {$urandom, $urandom};
      cycle(($urandom_range(0, 49) == 0), CH'($urandom), $urandom_range(0, 1),
            int'($urandom_range(0, CH - 1)), ($urandom_range(0, 3) != 0), rnd);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
